// File: rtl/jm_engine_pkg.sv
// Shared definitions for the job-scheduler engine endpoint: descriptor field
// positions, internally generated status codes and the endpoint FSM states.
package jm_engine_pkg;

  // Job descriptor field layout (LSB position and width within jd_payload)
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 8;
  localparam int FLAGS_LSB  = 8;
  localparam int FLAGS_W    = 8;
  localparam int JOB_ID_LSB = 32;
  localparam int JOB_ID_W   = 32;
  localparam int SRC_LSB    = 64;
  localparam int SRC_W      = 64;
  localparam int DST_LSB    = 128;
  localparam int DST_W      = 64;
  localparam int LEN_LSB    = 192;
  localparam int LEN_W      = 32;

  // Highest descriptor bit actually decoded
  localparam int DESC_MSB   = LEN_LSB + LEN_W - 1;

  // Status codes produced by the endpoint itself
  localparam logic [7:0] ST_ZERO_LEN = 8'hFE;
  localparam logic [7:0] ST_TIMEOUT  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } jm_state_e;

endpackage

// File: rtl/jm_watchdog.sv
// Watchdog counter: held at zero while disabled, counts one per cycle while
// enabled, and flags expiry on the cycle the count reaches limit-1.
// A limit of zero disables expiry entirely.
module jm_watchdog #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  // Restart from zero every time the enable window opens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!en) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = en && (limit != '0) && (count_q == (limit - 1'b1));

endmodule

// File: rtl/jm_engine_endpoint.sv
// Kernel-side endpoint of the scheduler handshake. Captures a job descriptor
// on engine_start, offers it to the kernel over valid/ready, supervises the
// run with a watchdog and returns a one-cycle engine_done with the status.
module jm_engine_endpoint
  import jm_engine_pkg::*;
#(
  parameter int          HOST_DWIDTH    = 1024,   // must be >= 256
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   engine_start,
  input  logic [HOST_DWIDTH-1:0] jd_payload,
  output logic                   engine_done,
  output logic                   k_job_valid,
  input  logic                   k_job_ready,
  output logic [7:0]             k_opcode,
  output logic [7:0]             k_flags,
  output logic [31:0]            k_job_id,
  output logic [63:0]            k_src_addr,
  output logic [63:0]            k_dst_addr,
  output logic [31:0]            k_length,
  input  logic                   k_done,
  input  logic [7:0]             k_status,
  output logic                   k_abort,
  output logic                   busy,
  output logic [7:0]             last_status,
  output logic [31:0]            job_count,
  output logic                   err_overlap
);

  jm_state_e   state_q;
  jm_state_e   state_d;
  logic        accept_start;
  logic        start_len_zero;
  logic        commit;
  logic [7:0]  commit_status;
  logic        abort_d;
  logic        wd_expired;

  // Payload bits outside the decoded fields are intentionally ignored
  logic        payload_unused;
  assign payload_unused = ^{jd_payload[HOST_DWIDTH-1:DESC_MSB+1],
                            jd_payload[JOB_ID_LSB-1:FLAGS_LSB+FLAGS_W]};

  assign accept_start   = engine_start && (state_q == S_IDLE);
  assign start_len_zero = (jd_payload[LEN_LSB +: LEN_W] == '0);

  // The watchdog only runs while the kernel owns the job
  jm_watchdog #(
    .CNT_W (32)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == S_RUN),
    .limit   (TIMEOUT_CYCLES),
    .expired (wd_expired)
  );

  // Next-state logic; commit marks the cycle a job's result is decided
  always_comb begin
    state_d       = state_q;
    commit        = 1'b0;
    commit_status = 8'h00;
    abort_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (engine_start) begin
          if (start_len_zero) begin
            state_d       = S_DONE;
            commit        = 1'b1;
            commit_status = ST_ZERO_LEN;
          end else begin
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (k_job_ready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Kernel completion takes priority over a simultaneous expiry
        if (k_done) begin
          state_d       = S_DONE;
          commit        = 1'b1;
          commit_status = k_status;
        end else if (wd_expired) begin
          state_d       = S_DONE;
          commit        = 1'b1;
          commit_status = ST_TIMEOUT;
          abort_d       = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Descriptor register: only an accepted start may overwrite it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_opcode   <= '0;
      k_flags    <= '0;
      k_job_id   <= '0;
      k_src_addr <= '0;
      k_dst_addr <= '0;
      k_length   <= '0;
    end else if (accept_start) begin
      k_opcode   <= jd_payload[OPCODE_LSB +: OPCODE_W];
      k_flags    <= jd_payload[FLAGS_LSB  +: FLAGS_W];
      k_job_id   <= jd_payload[JOB_ID_LSB +: JOB_ID_W];
      k_src_addr <= jd_payload[SRC_LSB    +: SRC_W];
      k_dst_addr <= jd_payload[DST_LSB    +: DST_W];
      k_length   <= jd_payload[LEN_LSB    +: LEN_W];
    end
  end

  // Result bookkeeping, valid alongside the engine_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_status <= '0;
      job_count   <= '0;
    end else if (commit) begin
      last_status <= commit_status;
      job_count   <= job_count + 32'd1;
    end
  end

  // Sticky flag for a start arriving while a job is still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overlap <= 1'b0;
    end else if (engine_start && (state_q != S_IDLE)) begin
      err_overlap <= 1'b1;
    end
  end

  assign engine_done = (state_q == S_DONE);
  assign k_job_valid = (state_q == S_DISPATCH);
  assign busy        = (state_q != S_IDLE);
  assign k_abort     = abort_d;

endmodule

// File: doc/jm_engine_endpoint.md
Name: jm_engine_endpoint

Overview:
Kernel-side endpoint of the job-scheduler engine handshake (engine_start / jd_payload / engine_done), one instance per kernel slot. It captures the job descriptor on an engine_start pulse and decodes the descriptor fields. It hands the job to the kernel datapath over a valid/ready handshake, waits for kernel completion under a watchdog, and returns a single-cycle engine_done pulse to the scheduler.

Parameters:
HOST_DWIDTH, 1024, width of jd_payload; must be >= 256.
TIMEOUT_CYCLES, 32'd1048576, watchdog limit in RUN, counted in clk cycles; 0 disables the watchdog.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
engine_start  input  1  single-cycle job-start pulse from the scheduler
jd_payload  input  HOST_DWIDTH  job descriptor, valid only in the engine_start cycle
engine_done  output  1  single-cycle completion pulse to the scheduler
k_job_valid  output  1  job offered to the kernel
k_job_ready  input  1  kernel accepts the job
k_opcode  output  8  jd_payload[7:0]
k_flags  output  8  jd_payload[15:8]
k_job_id  output  32  jd_payload[63:32]
k_src_addr  output  64  jd_payload[127:64]
k_dst_addr  output  64  jd_payload[191:128]
k_length  output  32  jd_payload[223:192], in bytes
k_done  input  1  kernel finished the current job
k_status  input  8  kernel return code, sampled with k_done
k_abort  output  1  single-cycle abort request to the kernel on timeout
busy  output  1  high when state != IDLE
last_status  output  8  status of the most recently completed job
job_count  output  32  number of completed jobs, wraps 0xFFFFFFFF->0
err_overlap  output  1  sticky: engine_start received while busy

Behaviour:
- Reset (async on rst_n low; release synchronous to clk): state=IDLE. All outputs 0, including descriptor fields, last_status, job_count and err_overlap. Reset mid-job drops the job without an engine_done pulse.
- Descriptor register: loaded only when engine_start=1 in IDLE. k_* fields are driven from this register and stay stable until the next accepted start.
- FSM states: IDLE, DISPATCH, RUN, DONE.
- IDLE, engine_start=1, k_length!=0 in the payload: go to DISPATCH. k_job_valid=1 from cycle T+1.
- IDLE, engine_start=1, length==0: go to DONE directly. Status 0xFE. The kernel is never offered the job.
- DISPATCH: hold k_job_valid=1 and the fields stable until k_job_ready=1. Handshake completes in that cycle; next state is RUN with k_job_valid=0.
- RUN: watchdog counter (32 b) starts at 0 on RUN entry and increments each cycle.
- RUN, k_done=1: capture k_status and go to DONE.
- RUN, counter reaches TIMEOUT_CYCLES-1 with k_done=0: k_abort=1 for that one cycle, status 0xFF, go to DONE.
- RUN, k_done and timeout in the same cycle: k_done wins, no abort.
- DONE (exactly one cycle): engine_done=1, last_status updated, job_count+1, then IDLE.
- Latency: k_done at cycle U gives engine_done at U+1. A zero-length start at T gives engine_done at T+1.
- The watchdog is not active in DISPATCH; the kernel may stall ready indefinitely.
- k_done outside RUN is ignored, including in the same cycle as the k_job_ready handshake.
- engine_start in any state other than IDLE (including DONE) is ignored: the descriptor is unchanged and err_overlap is set to 1, cleared only by reset.
- k_status 0xFE and 0xFF from the kernel are passed through unmodified; they are indistinguishable from the internal codes by design.

Decomposition:
- Shared package jm_engine_pkg holds:
  - descriptor field LSB/width constants: OPCODE, FLAGS, JOB_ID, SRC, DST, LEN;
  - status constants ST_ZERO_LEN=8'hFE and ST_TIMEOUT=8'hFF;
  - the FSM state enum.
- Sub-module jm_watchdog: load-on-enable counter with expiry flag and zero-disable. It is reusable by the job_manager read path.

Test Plan:
1. Normal job: start with len=0x100, opcode=0x21; ready after 3 cycles; k_done with status 0x00 ten cycles later -> fields match the payload, one engine_done pulse at U+1, last_status=0x00, job_count=1.
2. Zero length: start with len=0 -> k_job_valid never asserted, engine_done at T+1, last_status=0xFE.
3. Timeout: TIMEOUT_CYCLES=16, kernel never asserts k_done -> k_abort pulse on the 16th RUN cycle, engine_done next cycle, last_status=0xFF.
4. Tie: TIMEOUT_CYCLES=16, k_done=1 with status 0x05 in the 16th RUN cycle -> no k_abort, last_status=0x05.
5. Overlap: second engine_start in DISPATCH and again in the DONE cycle -> descriptor unchanged, err_overlap=1, exactly one engine_done.
6. Reset in RUN: rst_n low for 2 cycles -> busy=0, no engine_done, job_count=0; the next job completes normally.
